id_ex_stage: RTL

- Decode-to-execute pipeline stage that sits directly downstream of the register file.
- Consumes BusA/BusB plus the IF/ID instruction fields and applies a WB-to-ID bypass, because the register file writes at the clock edge while reads are combinational.
- Detects load-use hazards against the instruction already held in ID/EX, inserts bubbles, and registers operands and control for the EX stage.
- Honours a branch flush from EX and a hold request from downstream.

---
 rtl/id_ex_stage_pkg.sv | 28 ++
 rtl/id_bypass_mux.sv | 19 +
 rtl/id_ex_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: instruction field positions, the
// register-zero constant, the EX control flag bundle and the immediate extender.
package id_ex_stage_pkg;

    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // The opaque ctrl field travels beside this bundle because its width is a
    // parameter of the stage, and a package typedef cannot depend on it.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ex_flags_t;

    localparam ex_flags_t FLAGS_NONE = '0;

    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic zero_ext);
        return zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/id_bypass_mux.sv
// WB-to-ID bypass for one source operand: the register file writes at the
// clock edge, so a same-cycle WB write to the source register must win.
module id_bypass_mux
    import id_ex_stage_pkg::*;
(
    input  logic [4:0]  src_reg_i,
    input  logic [31:0] reg_data_i,
    input  logic [4:0]  wb_reg_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] op_o
);

    logic hit;

    assign hit  = wb_we_i && (wb_reg_i != REG_ZERO) && (wb_reg_i == src_reg_i);
    assign op_o = hit ? wb_data_i : reg_data_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, load-use bubble insertion, flush and hold.
// Optional load-use stall counter port enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              if_id_valid,
    input  logic [31:0]       if_id_instr,
    input  logic [31:0]       if_id_pc,
    input  logic [4:0]        id_rw,
    input  logic              id_usesRt,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    input  logic              id_memWrite,
    input  logic              id_zeroExt,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       BusA,
    input  logic [31:0]       BusB,
    input  logic [4:0]        rw5,
    input  logic              regWrite5,
    input  logic [31:0]       Busw,
    input  logic              ex_flush,
    input  logic              ex_hold,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [31:0]       ex_opA,
    output logic [31:0]       ex_opB,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rw,
    output logic [31:0]       ex_pc,
    output logic              ex_regWrite,
    output logic              ex_memRead,
    output logic              ex_memWrite,
    output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] opa_n;
    logic [31:0] opb_n;
    logic        hazard;
    logic        unused_ok;

    logic              valid_q, valid_d;
    ex_flags_t         flags_q, flags_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [31:0]       opa_q,   opa_d;
    logic [31:0]       opb_q,   opb_d;
    logic [31:0]       imm_q,   imm_d;
    logic [4:0]        rs_q,    rs_d;
    logic [4:0]        rt_q,    rt_d;
    logic [4:0]        rw_q,    rw_d;
    logic [31:0]       pc_q,    pc_d;

    assign rs        = if_id_instr[RS_MSB:RS_LSB];
    assign rt        = if_id_instr[RT_MSB:RT_LSB];
    assign imm       = if_id_instr[IMM_MSB:IMM_LSB];
    assign unused_ok = &{1'b0, if_id_instr[31:26]};

    id_bypass_mux u_bypass_a (
        .src_reg_i  (rs),
        .reg_data_i (BusA),
        .wb_reg_i   (rw5),
        .wb_we_i    (regWrite5),
        .wb_data_i  (Busw),
        .op_o       (opa_n)
    );

    id_bypass_mux u_bypass_b (
        .src_reg_i  (rt),
        .reg_data_i (BusB),
        .wb_reg_i   (rw5),
        .wb_we_i    (regWrite5),
        .wb_data_i  (Busw),
        .op_o       (opb_n)
    );

    assign hazard = valid_q && flags_q.mem_read && (rw_q != REG_ZERO) && if_id_valid &&
                    ((rw_q == rs) || (id_usesRt && (rw_q == rt)));

    // A flush kills the instruction in ID, so there is nothing to stall for.
    assign stall_id = Reset_L && !ex_flush && (ex_hold || hazard);

    always_comb begin
        valid_d = valid_q;
        flags_d = flags_q;
        ctrl_d  = ctrl_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rw_d    = rw_q;
        pc_d    = pc_q;
        if (ex_flush) begin
            valid_d = 1'b0;
            flags_d = FLAGS_NONE;
            ctrl_d  = '0;
        end else if (!ex_hold) begin
            if (hazard) begin
                valid_d = 1'b0;
                flags_d = FLAGS_NONE;
                ctrl_d  = '0;
            end else begin
                valid_d = if_id_valid;
                flags_d = if_id_valid ? '{reg_write: id_regWrite,
                                          mem_read:  id_memRead,
                                          mem_write: id_memWrite} : FLAGS_NONE;
                ctrl_d  = if_id_valid ? id_ctrl : '0;
                opa_d   = opa_n;
                opb_d   = opb_n;
                imm_d   = extend_imm(imm, id_zeroExt);
                rs_d    = rs;
                rt_d    = rt;
                rw_d    = id_rw;
                pc_d    = if_id_pc;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            valid_q <= 1'b0;
            flags_q <= FLAGS_NONE;
            ctrl_q  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rw_q    <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            flags_q <= flags_d;
            ctrl_q  <= ctrl_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rw_q    <= rw_d;
            pc_q    <= pc_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_opA      = opa_q;
    assign ex_opB      = opb_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_rw       = rw_q;
    assign ex_pc       = pc_q;
    assign ex_regWrite = flags_q.reg_write;
    assign ex_memRead  = flags_q.mem_read;
    assign ex_memWrite = flags_q.mem_write;
    assign ex_ctrl     = ctrl_q;

`ifdef ID_EX_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (hazard && !ex_flush && !ex_hold && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;
`else
    localparam int UNUSED_CNT_W = CNT_W;
`endif

endmodule
